// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op encodings, cycle defaults and issue classification
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MTHI     = 4'd5,
        MTLO     = 4'd6,
        MFHI     = 4'd7,
        MFLO     = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    // Also used by the stall unit to decide whether E holds a multi-cycle op.
    function automatic logic is_mdu_start(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - combinational signed/unsigned 32-bit divider with zero-divisor flag
module mdu_div_core (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        neg_dividend;
    logic        neg_divisor;
    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;
    logic [31:0] safe_divisor;
    logic [31:0] uq;
    logic [31:0] ur;

    // Magnitude divide then re-sign: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
    always_comb begin
        neg_dividend = is_signed & dividend[31];
        neg_divisor  = is_signed & divisor[31];
        abs_dividend = neg_dividend ? (~dividend + 32'd1) : dividend;
        abs_divisor  = neg_divisor  ? (~divisor + 32'd1)  : divisor;
        div_by_zero  = (divisor == 32'd0);
        safe_divisor = div_by_zero ? 32'd1 : abs_divisor;
        uq           = abs_dividend / safe_divisor;
        ur           = abs_dividend % safe_divisor;
        quotient     = (neg_dividend ^ neg_divisor) ? (~uq + 32'd1) : uq;
        remainder    = neg_dividend ? (~ur + 32'd1) : ur;
    end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with fixed latency and HI/LO registers
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] out
);

    mdu_state_e  state, state_next;
    logic [3:0]  counter, counter_next;
    logic [31:0] hi, hi_next;
    logic [31:0] lo, lo_next;
    logic [31:0] pending_hi, pending_hi_next;
    logic [31:0] pending_lo, pending_lo_next;
    logic        pending_commit, pending_commit_next;

    logic        issue;
    logic        is_mult;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    mdu_div_core u_div_core (
        .dividend    (rs),
        .divisor     (rt),
        .is_signed   (op == DIV),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    assign busy = (state == MDU_BUSY);

    // Sign-extending both operands to 64 bits makes the low 64 bits of one
    // multiplier correct for both signed and unsigned products.
    always_comb begin
        issue      = start && !busy && !req && is_mdu_start(op);
        is_mult    = (op == MULT) || (op == MULTU);
        mul_signed = (op == MULT);
        mul_a      = {{32{mul_signed & rs[31]}}, rs};
        mul_b      = {{32{mul_signed & rt[31]}}, rt};
        product    = mul_a * mul_b;
    end

    always_comb begin
        state_next          = state;
        counter_next        = counter;
        hi_next             = hi;
        lo_next             = lo;
        pending_hi_next     = pending_hi;
        pending_lo_next     = pending_lo;
        pending_commit_next = pending_commit;

        if (issue) begin
            state_next   = MDU_BUSY;
            counter_next = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            if (is_mult) begin
                {pending_hi_next, pending_lo_next} = product;
                pending_commit_next                = 1'b1;
            end else begin
                pending_hi_next     = remainder;
                pending_lo_next     = quotient;
                pending_commit_next = !div_by_zero;
            end
        end else if (busy) begin
            counter_next = counter - 4'd1;
            if (counter == 4'd1) begin
                state_next = MDU_IDLE;
                if (pending_commit) begin
                    hi_next = pending_hi;
                    lo_next = pending_lo;
                end
            end
        end else if (!req) begin
            if (op == MTHI) hi_next = rs;
            if (op == MTLO) lo_next = rs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= MDU_IDLE;
            counter        <= 4'd0;
            hi             <= 32'd0;
            lo             <= 32'd0;
            pending_hi     <= 32'd0;
            pending_lo     <= 32'd0;
            pending_commit <= 1'b0;
        end else begin
            state          <= state_next;
            counter        <= counter_next;
            hi             <= hi_next;
            lo             <= lo_next;
            pending_hi     <= pending_hi_next;
            pending_lo     <= pending_lo_next;
            pending_commit <= pending_commit_next;
        end
    end

    always_comb begin
        case (op)
            MFHI:    out = hi;
            MFLO:    out = lo;
            default: out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed self-checking bench for e_mdu
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;
    int n;

    e_mdu dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs = a; rt = b; start = 1'b1;
        step();
        start = 1'b0; op = MDU_NONE; rs = 32'd0; rt = 32'd0;
    endtask

    task automatic write_hilo(input logic [3:0] o, input logic [31:0] a);
        op = o; rs = a;
        step();
        op = MDU_NONE; rs = 32'd0;
    endtask

    // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [3:0] saved;
        saved = op;
        op = MFHI; #1;
        check({tag, "_hi"}, out, exp_hi);
        op = MFLO; #1;
        check({tag, "_lo"}, out, exp_lo);
        op = saved; #1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; op = MDU_NONE; rs = 32'd0; rt = 32'd0;
        step(); step();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);
        check("none_out", out, 32'd0);

        issue(MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        check("mult_busy_cycles", n, 32'd5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        check("multu_busy_cycles", n, 32'd5);
        check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_busy_cycles", n, 32'd10);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        write_hilo(MTHI, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check_hilo("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
        issue(DIVU, 32'd5, 32'd0);
        wait_idle(n);
        check("divu0_busy_cycles", n, 32'd10);
        check_hilo("divu0", 32'h1234_5678, 32'hFFFF_FFFD);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf_busy_cycles", n, 32'd10);
        check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        req = 1'b1;
        issue(MULT, 32'd3, 32'd4);
        check("req_mult_busy", {31'd0, busy}, 32'd0);
        write_hilo(MTLO, 32'h0000_00AA);
        req = 1'b0;
        step(); step();
        check("req_busy_later", {31'd0, busy}, 32'd0);
        check_hilo("req_flush", 32'h0000_0000, 32'h8000_0000);

        issue(MULT, 32'd6, 32'd7);
        wait_idle(n);
        check("b2b_mult_cycles", n, 32'd5);
        check_hilo("b2b_mult", 32'd0, 32'd42);
        issue(DIV, 32'd100, 32'd7);
        check("b2b_div_accepted", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("b2b_div_cycles", n, 32'd10);
        check_hilo("b2b_div", 32'd2, 32'd14);

        issue(MULTU, 32'd10, 32'd10);
        step();
        op = DIV; rs = 32'd99; rt = 32'd3; start = 1'b1;
        step();
        start = 1'b0; op = MDU_NONE; rs = 32'd0; rt = 32'd0;
        wait_idle(n);
        check("start_while_busy_rest", n, 32'd3);
        check_hilo("start_while_busy", 32'd0, 32'd100);

        issue(MULT, 32'd2, 32'd3);
        step(); step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check_hilo("mid_reset", 32'd0, 32'd0);
        step(); step(); step(); step();
        check_hilo("mid_reset_later", 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
